pipe_ctrl: RTL and testbench
============================

Name: pipe_ctrl

Overview:
- Central pipeline control unit for the 5-stage core.
- Merges stall requests from IF, ID, EX and MEM into the 6-bit stall vector consumed by pc_reg, if_id, id_ex, ex_mem and mem_wb.
- Raises flush with the redirect PC on exceptions and ERET, and supervises stall duration with a watchdog that forces recovery.
- Keeps saturating stall and flush counters for software and debug.

Parameters:
- EXC_VECTOR, 32'h00000040, redirect PC for all non-ERET exceptions.
- WDT_VECTOR, 32'h00000080, redirect PC on watchdog recovery.
- MAX_STALL, 1024, consecutive stalled cycles that trigger the watchdog (≥2).
- CNT_W, 32, width of stall_cycles counter.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- stallreq_from_if  in  1  instruction bus wait.
- stallreq_from_id  in  1  load-use hazard.
- stallreq_from_ex  in  1  multi-cycle op (madd/msub/div) busy.
- stallreq_from_mem  in  1  data bus wait.
- excepttype_i  in  32  final exception type from MEM stage (0 = none, 32'h0000000e = ERET).
- cp0_epc_i  in  32  current EPC (bypassed) from MEM.
- stall  out  6  bit0 PC, 1 IF, 2 ID, 3 EX, 4 MEM, 5 WB; 1 = hold.
- flush  out  1  clear all pipeline registers this edge.
- new_pc  out  32  redirect target, valid when flush=1.
- stall_timeout  out  1  sticky: watchdog fired since reset.
- stall_cycles  out  CNT_W  saturating count of cycles with stall≠0.
- flush_count  out  16  saturating count of flush pulses.

Behaviour:
- Reset is asynchronous and active-high. While rst=1: state=RUN, watchdog counter=0, stall_timeout=0, stall_cycles=0, flush_count=0.
- Outputs during reset: stall=0, flush=0, new_pc=0.
- stall, flush and new_pc are combinational from the inputs and state. They take effect at the same edge as the requesting condition, with zero-cycle latency.
- Stall priority, highest first:
  - flush active → 6'b000000.
  - mem → 6'b011111.
  - ex → 6'b001111.
  - id → 6'b000111.
  - if → 6'b000111.
  - none → 0.
- Exception acceptance: excepttype_i≠0 and stallreq_from_mem=0 → flush=1, stall=0.
  - new_pc = cp0_epc_i when excepttype_i==32'h0000000e, else EXC_VECTOR.
  - While stallreq_from_mem=1, the exception waits (MEM stage is held) and normal stalling applies.
- Watchdog counter:
  - In RUN, increments each cycle stall≠0.
  - Clears to 0 on any cycle stall==0 or flush=1.
- FSM states:
  - RUN: normal operation. When the counter reaches MAX_STALL-1 while stall is still ≠0, go to WDT at the next edge.
  - WDT: lasts exactly one cycle. Forces flush=1, new_pc=WDT_VECTOR, stall=0, regardless of stall requests and excepttype_i. Sets stall_timeout=1 and clears the counter. Next state is RUN.
  - A pending exception in WDT is dropped; it is the flush victim.
- stall_cycles: +1 per cycle with stall≠0 (evaluated on the output). Saturates at all-ones.
- flush_count: +1 per cycle with flush=1. Saturates at 16'hFFFF.
- stall_timeout clears only on rst.
- Reset asserted mid-stall or mid-WDT: all outputs drop asynchronously to their reset values and the FSM returns to RUN.

Test Plan:
- Reset sanity: rst pulse asynchronously mid-cycle during mem stall → stall=0, flush=0, counters=0 immediately. After release with no requests, stall stays 0.
- Priority: assert if, id, ex, mem together → stall=6'b011111. Drop mem → 001111. Drop ex → 000111. Drop id → 000111 (IF only). Drop all → 000000. stall_cycles ends at 4.
- Exception accept: excepttype_i=32'h00000008, no mem stall → flush=1, new_pc=32'h00000040, stall=0, flush_count=1.
- ERET: excepttype_i=32'h0000000e, cp0_epc_i=32'h1000_0120 → new_pc=32'h1000_0120, flush=1.
- Exception held by mem stall: excepttype_i=8 with stallreq_from_mem=1 for 3 cycles → stall=011111, flush=0 for those cycles. flush=1 in the cycle mem releases.
- Watchdog: MAX_STALL=8, stallreq_from_ex held high → stall=001111 for 8 cycles. Cycle 9 gives flush=1, new_pc=32'h00000080, stall=0, stall_timeout=1. Cycle 10 returns to 001111 and the counter restarts from 0.

Source files
------------

// File: rtl/pipe_ctrl_if.sv
// Pipeline control bus: stall requests and exception info in, stall/flush/redirect and status out.
interface pipe_ctrl_if #(
  parameter int CNT_W = 32
);
  logic             stallreq_from_if;
  logic             stallreq_from_id;
  logic             stallreq_from_ex;
  logic             stallreq_from_mem;
  logic [31:0]      excepttype_i;
  logic [31:0]      cp0_epc_i;
  logic [5:0]       stall;
  logic             flush;
  logic [31:0]      new_pc;
  logic             stall_timeout;
  logic [CNT_W-1:0] stall_cycles;
  logic [15:0]      flush_count;

  modport master (
    input  stallreq_from_if, stallreq_from_id, stallreq_from_ex, stallreq_from_mem,
    input  excepttype_i, cp0_epc_i,
    output stall, flush, new_pc, stall_timeout, stall_cycles, flush_count
  );

  modport slave (
    output stallreq_from_if, stallreq_from_id, stallreq_from_ex, stallreq_from_mem,
    output excepttype_i, cp0_epc_i,
    input  stall, flush, new_pc, stall_timeout, stall_cycles, flush_count
  );
endinterface

// File: rtl/pipe_ctrl.sv
// Central stall/flush control for the 5-stage core with a stall watchdog
// and saturating stall/flush statistics.
module pipe_ctrl #(
  parameter logic [31:0] EXC_VECTOR = 32'h0000_0040,
  parameter logic [31:0] WDT_VECTOR = 32'h0000_0080,
  parameter int          MAX_STALL  = 1024,
  parameter int          CNT_W      = 32
) (
  input  logic        clk,
  input  logic        rst,
  pipe_ctrl_if.master bus
);
  localparam int WDT_W = (MAX_STALL > 2) ? $clog2(MAX_STALL) : 1;
  localparam logic [WDT_W-1:0] WDT_LAST = WDT_W'(MAX_STALL - 1);
  localparam logic [31:0] ERET_CODE = 32'h0000_000e;

  typedef enum logic {RUN, WDT} state_t;

  state_t           state;
  logic [WDT_W-1:0] wdt_cnt;
  logic             timeout;
  logic [CNT_W-1:0] stall_cyc;
  logic [15:0]      flush_cnt;

  logic [5:0]  stall_c;
  logic        flush_c;
  logic [31:0] new_pc_c;
  logic        exc_take;

  // An exception is only accepted once MEM is no longer waiting on the bus.
  assign exc_take = (bus.excepttype_i != 32'd0) && !bus.stallreq_from_mem;

  always_comb begin
    stall_c  = 6'b000000;
    flush_c  = 1'b0;
    new_pc_c = 32'd0;
    if (rst) begin
      stall_c = 6'b000000;
    end else if (state == WDT) begin
      flush_c  = 1'b1;
      new_pc_c = WDT_VECTOR;
    end else if (exc_take) begin
      flush_c  = 1'b1;
      new_pc_c = (bus.excepttype_i == ERET_CODE) ? bus.cp0_epc_i : EXC_VECTOR;
    end else if (bus.stallreq_from_mem) begin
      stall_c = 6'b011111;
    end else if (bus.stallreq_from_ex) begin
      stall_c = 6'b001111;
    end else if (bus.stallreq_from_id || bus.stallreq_from_if) begin
      stall_c = 6'b000111;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= RUN;
      wdt_cnt   <= '0;
      timeout   <= 1'b0;
      stall_cyc <= '0;
      flush_cnt <= 16'd0;
    end else begin
      if ((stall_c != 6'b000000) && (stall_cyc != {CNT_W{1'b1}}))
        stall_cyc <= stall_cyc + 1'b1;
      if (flush_c && (flush_cnt != 16'hFFFF))
        flush_cnt <= flush_cnt + 16'd1;
      case (state)
        RUN: begin
          if ((stall_c == 6'b000000) || flush_c) begin
            wdt_cnt <= '0;
          end else if (wdt_cnt == WDT_LAST) begin
            // Sticky flag goes up on entry so it is visible during the recovery flush.
            state   <= WDT;
            wdt_cnt <= '0;
            timeout <= 1'b1;
          end else begin
            wdt_cnt <= wdt_cnt + 1'b1;
          end
        end
        WDT: begin
          state   <= RUN;
          wdt_cnt <= '0;
        end
        default: begin
          state   <= RUN;
          wdt_cnt <= '0;
        end
      endcase
    end
  end

  assign bus.stall         = stall_c;
  assign bus.flush         = flush_c;
  assign bus.new_pc        = new_pc_c;
  assign bus.stall_timeout = timeout;
  assign bus.stall_cycles  = stall_cyc;
  assign bus.flush_count   = flush_cnt;
endmodule

// File: tb/tb_pipe_ctrl.sv
// Bench for pipe_ctrl: directed scenarios plus random traffic against a
// rule-level reference model of stall priority, exceptions and the watchdog.
module tb_pipe_ctrl;
  localparam int MAXS = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pipe_ctrl_if #(.CNT_W(32)) bus ();

  pipe_ctrl #(
    .EXC_VECTOR(32'h0000_0040),
    .WDT_VECTOR(32'h0000_0080),
    .MAX_STALL (MAXS),
    .CNT_W     (32)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.master)
  );

  int nchk = 0;
  int nerr = 0;

  // reference model state
  bit          m_wdt;
  bit          m_to;
  int          m_run;
  longint      m_cyc;
  int          m_fc;
  logic [5:0]  e_stall;
  logic        e_flush;
  logic [31:0] e_pc;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nchk++;
    if (obs !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic drv(input bit i, input bit d, input bit e, input bit m,
                     input logic [31:0] exc, input logic [31:0] epc);
    bus.stallreq_from_if  = i;
    bus.stallreq_from_id  = d;
    bus.stallreq_from_ex  = e;
    bus.stallreq_from_mem = m;
    bus.excepttype_i      = exc;
    bus.cp0_epc_i         = epc;
  endtask

  task automatic model_reset();
    m_wdt = 0; m_to = 0; m_run = 0; m_cyc = 0; m_fc = 0;
  endtask

  task automatic model_outs();
    e_stall = 6'b0; e_flush = 1'b0; e_pc = 32'd0;
    if (m_wdt) begin
      e_flush = 1'b1; e_pc = 32'h80;
    end else if (bus.excepttype_i != 0 && !bus.stallreq_from_mem) begin
      e_flush = 1'b1;
      e_pc = (bus.excepttype_i == 32'he) ? bus.cp0_epc_i : 32'h40;
    end else if (bus.stallreq_from_mem) e_stall = 6'b011111;
    else if (bus.stallreq_from_ex)       e_stall = 6'b001111;
    else if (bus.stallreq_from_id)       e_stall = 6'b000111;
    else if (bus.stallreq_from_if)       e_stall = 6'b000111;
  endtask

  task automatic model_update();
    if (e_stall != 0) m_cyc++;
    if (e_flush && m_fc != 65535) m_fc++;
    if (m_wdt) begin
      m_wdt = 0; m_run = 0;
    end else if (e_stall != 0) begin
      m_run++;  // consecutive stalled cycles including this one
      if (m_run == MAXS) begin m_wdt = 1; m_to = 1; m_run = 0; end
    end else begin
      m_run = 0;
    end
  endtask

  // Inputs are already driven; check mid-cycle, then advance one clock.
  task automatic step();
    @(negedge clk);
    model_outs();
    chk("stall",         64'(bus.stall),         64'(e_stall));
    chk("flush",         64'(bus.flush),         64'(e_flush));
    chk("new_pc",        64'(bus.new_pc),        64'(e_pc));
    chk("stall_timeout", 64'(bus.stall_timeout), 64'(m_to));
    chk("stall_cycles",  64'(bus.stall_cycles),  64'(m_cyc));
    chk("flush_count",   64'(bus.flush_count),   64'(m_fc));
    @(posedge clk);
    model_update();
    #1;
  endtask

  initial begin
    rst = 1'b1;
    drv(0, 0, 0, 0, 32'd0, 32'd0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_stall", 64'(bus.stall), 64'd0);
    chk("rst_flush", 64'(bus.flush), 64'd0);
    chk("rst_pc",    64'(bus.new_pc), 64'd0);
    rst = 1'b0;

    // mem stall then asynchronous reset mid-cycle
    drv(0, 0, 0, 1, 32'd0, 32'd0);
    step(); step(); step();
    #2 rst = 1'b1;
    #1;
    chk("arst_stall",  64'(bus.stall),         64'd0);
    chk("arst_flush",  64'(bus.flush),         64'd0);
    chk("arst_cycles", 64'(bus.stall_cycles),  64'd0);
    chk("arst_fcount", 64'(bus.flush_count),   64'd0);
    chk("arst_to",     64'(bus.stall_timeout), 64'd0);
    @(posedge clk); #1;
    drv(0, 0, 0, 0, 32'd0, 32'd0);
    rst = 1'b0;
    model_reset();
    step(); step();

    // priority ladder
    drv(1, 1, 1, 1, 32'd0, 32'd0); step();
    drv(1, 1, 1, 0, 32'd0, 32'd0); step();
    drv(1, 1, 0, 0, 32'd0, 32'd0); step();
    drv(1, 0, 0, 0, 32'd0, 32'd0); step();
    drv(0, 0, 0, 0, 32'd0, 32'd0); step();
    chk("prio_cycles", 64'(bus.stall_cycles), 64'd4);

    // exception and ERET
    drv(0, 0, 0, 0, 32'h8, 32'h0); step();
    chk("exc_fcount", 64'(bus.flush_count), 64'd1);
    drv(0, 0, 0, 0, 32'he, 32'h1000_0120); step();
    drv(0, 0, 0, 0, 32'd0, 32'd0); step();

    // exception held behind mem stall
    drv(0, 0, 0, 1, 32'h8, 32'h0);
    repeat (3) step();
    drv(0, 0, 0, 0, 32'h8, 32'h0); step();
    drv(0, 0, 0, 0, 32'd0, 32'd0); step();

    // watchdog on a stuck ex stall, two full periods
    drv(0, 0, 1, 0, 32'd0, 32'd0);
    repeat (2 * (MAXS + 1)) step();
    chk("wdt_sticky", 64'(bus.stall_timeout), 64'd1);
    chk("wdt_fcount", 64'(bus.flush_count), 64'(m_fc));

    // pending exception held by mem is dropped by the watchdog flush
    drv(0, 0, 0, 1, 32'h8, 32'h0);
    repeat (MAXS + 2) step();
    drv(0, 0, 0, 0, 32'd0, 32'd0); step();

    // random traffic in segments, alternating free-running and stall-heavy
    for (int seg = 0; seg < 30; seg++) begin
      bit heavy;
      heavy = seg[0];
      for (int c = 0; c < 20; c++) begin
        logic [31:0] exc;
        int r;
        r = int'($urandom_range(0, 99));
        exc = 32'd0;
        if (!heavy && r < 10) exc = r[0] ? 32'h8 : 32'he;
        if (heavy)
          drv($urandom_range(0, 3) != 0, 1'b0, 1'b1, $urandom_range(0, 5) == 0,
              $urandom_range(0, 15) == 0 ? 32'h20 : 32'd0, $urandom);
        else
          drv($urandom_range(0, 1) == 1, $urandom_range(0, 3) == 0,
              $urandom_range(0, 3) == 0, $urandom_range(0, 4) == 0, exc, $urandom);
        step();
      end
    end

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
